// File: rtl/idct_1d_8x1.sv
`default_nettype none
// ============================================================================
//  Module   : idct_1d_8x1
//  Purpose  : 8-point one-dimensional inverse DCT. One output sample per
//             cycle is produced by a single shared 8-term multiply-add,
//             collected in shadow slots, then published all at once.
//  Ports    :
//    clk          - clock, rising edge active
//    reset        - synchronous active-high reset
//    data_in      - X[0..7], X[k] at [k*DATA_WIDTH +: DATA_WIDTH]
//    coeff_vector - basis matrix C, row k at [(7-k)*DATA_WIDTH*8 +: DATA_WIDTH*8],
//                   C[k][n] at [n*DATA_WIDTH +: DATA_WIDTH] within the row
//    start        - begin one transform (accepted only while ready)
//    ready        - high while idle
//    idct_out     - x[0..7], x[n] at [n*DATA_WIDTH +: DATA_WIDTH]
//    valid        - one-cycle pulse when idct_out has just been updated
//  Revision : 1.0 - initial release
// ============================================================================
module idct_1d_8x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH*8-1:0]   data_in,
  input  logic [DATA_WIDTH*64-1:0]  coeff_vector,
  input  logic                      start,
  output logic                      ready,
  output logic [DATA_WIDTH*8-1:0]   idct_out,
  output logic                      valid
);

  localparam int ACC_W = 2*DATA_WIDTH + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic [2:0]                r_idx;
  logic [DATA_WIDTH*8-1:0]   r_xin;
  logic [DATA_WIDTH*8-1:0]   r_shadow;
  logic [DATA_WIDTH*8-1:0]   w_xfix;
  logic signed [ACC_W-1:0]   w_prod [8];
  logic signed [ACC_W-1:0]   w_acc;
  logic [DATA_WIDTH-1:0]     w_res;

  // --------------------------------------------------------------------------
  // Input sign fix: odd-indexed coefficients are stored negated so the basis
  // matrix shared with the forward transform can be reused unchanged.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < 8; k++) begin : g_fix
      if (k % 2 == 1) begin : g_odd
        assign w_xfix[k*DATA_WIDTH +: DATA_WIDTH] = -data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_even
        assign w_xfix[k*DATA_WIDTH +: DATA_WIDTH] = data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Shared multiply-add: column r_idx of C against the latched inputs.
  // Operands are sign-extended to the full accumulator width before the
  // multiply so the sum of eight full-scale products cannot overflow.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < 8; k++) begin : g_mac
      logic signed [DATA_WIDTH-1:0] w_c;
      logic signed [DATA_WIDTH-1:0] w_x;
      assign w_c = coeff_vector[(7-k)*DATA_WIDTH*8 + int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
      assign w_x = r_xin[k*DATA_WIDTH +: DATA_WIDTH];
      assign w_prod[k] = ACC_W'(w_c) * ACC_W'(w_x);
    end
  endgenerate

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < 8; k++) begin
      w_acc = w_acc + w_prod[k];
    end
  end

  // Arithmetic shift back to integer scale, then wrap to the data width.
  assign w_res = DATA_WIDTH'(w_acc >>> FRAC_BITS);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (r_idx == 3'd7) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (r_state == S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath registers: input latch, output index, shadow slots, result.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= 3'd0;
      r_xin    <= '0;
      r_shadow <= '0;
      idct_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_xin <= w_xfix;
            r_idx <= 3'd0;
          end
        end
        S_CALC: begin
          r_shadow[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= w_res;
          r_idx <= r_idx + 3'd1;
        end
        S_DONE: begin
          idct_out <= r_shadow;
          valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idct_1d_8x1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idct_1d_8x1
//  Purpose  : Self-checking bench for idct_1d_8x1 (DATA_WIDTH=32, FRAC_BITS=16)
//             with a matrix-level reference model and directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_idct_1d_8x1;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [DW*8-1:0] data_in = '0;
  logic [DW*64-1:0] coeff_vector = '0;
  logic            ready;
  logic            valid;
  logic [DW*8-1:0] idct_out;

  idct_1d_8x1 #(.DATA_WIDTH(DW), .FRAC_BITS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .coeff_vector (coeff_vector),
    .start        (start),
    .ready        (ready),
    .idct_out     (idct_out),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  int C [8][8];
  int X [8];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW*8-1:0] act, input logic [DW*8-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drive the arrays onto the packed ports.
  task automatic apply();
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) coeff_vector[(7-k)*DW*8 + n*DW +: DW] = C[k][n];
      data_in[k*DW +: DW] = X[k];
    end
  endtask

  // x[n] = trunc32( (sum_k C[k][n] * s_k * X[k]) >>> 16 ), s_k = -1 for odd k.
  function automatic logic [DW*8-1:0] model();
    logic [DW*8-1:0]   r;
    logic signed [66:0] acc;
    int xs;
    for (int n = 0; n < 8; n++) begin
      acc = '0;
      for (int k = 0; k < 8; k++) begin
        xs  = (k % 2 == 1) ? -X[k] : X[k];
        acc = acc + 67'(C[k][n]) * 67'(xs);
      end
      r[n*DW +: DW] = 32'(acc >>> 16);
    end
    return r;
  endfunction

  task automatic set_identity();
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) C[k][n] = (k == n) ? 65536 : 0;
  endtask

  // ------------------------------------------------------------------
  // Scoreboard: every negedge, compare outputs to the model's view.
  // ------------------------------------------------------------------
  typedef struct { logic [DW*8-1:0] v; int due; } exp_t;
  exp_t q[$];
  int   cyc = 0;
  int   n_valid = 0;
  bit   rst_prev = 1'b0;
  bit   armed = 1'b0;
  bit   exp_valid = 1'b0;
  logic [DW*8-1:0] exp_out = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_prev) begin
      armed = 1'b1;
      exp_out = '0;
      q.delete();
      exp_valid = 1'b0;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      exp_out = q[0].v;
      exp_valid = 1'b1;
      void'(q.pop_front());
    end else begin
      exp_valid = 1'b0;
    end
    if (armed) begin
      chk("sb_valid", valid, exp_valid);
      chk("sb_idct_out", idct_out, exp_out);
      chk("sb_ready", ready, q.size() == 0);
    end
    if (valid) n_valid++;
    rst_prev = reset;
    if (!reset && armed && q.size() == 0 && start)
      q.push_back('{model(), cyc + 10});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic run_one(input string name, input logic [DW*8-1:0] expv);
    int lat;
    apply();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    chk({name, "_latency"}, lat, 9);
    chk(name, idct_out, expv);
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW*8-1:0] e;
    int v0;
    int lat;

    for (int k = 0; k < 8; k++) X[k] = 0;
    set_identity();
    apply();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_out", idct_out, '0);
    chk("reset_ready", ready, 1'b1);
    chk("reset_valid", valid, 1'b0);
    tick();

    // Identity basis: output is the sign-fixed input.
    for (int k = 0; k < 8; k++) X[k] = k + 1;
    for (int n = 0; n < 8; n++) e[n*DW +: DW] = (n % 2 == 1) ? -(n + 1) : (n + 1);
    run_one("identity", e);

    // Half-scale basis.
    for (int k = 0; k < 8; k++) for (int n = 0; n < 8; n++) C[k][n] = 32768;
    for (int k = 0; k < 8; k++) X[k] = (k % 2 == 0) ? 10 : 0;
    for (int n = 0; n < 8; n++) e[n*DW +: DW] = 32'd20;
    run_one("half_even", e);
    for (int k = 0; k < 8; k++) X[k] = (k % 2 == 1) ? 4 : 0;
    for (int n = 0; n < 8; n++) e[n*DW +: DW] = 32'hFFFF_FFF8;
    run_one("half_odd", e);

    // Start held high with data changing every cycle: one result per 10 cycles.
    set_identity();
    v0 = n_valid;
    start = 1'b1;
    for (int i = 0; i < 31; i++) begin
      for (int k = 0; k < 8; k++) X[k] = int'($urandom_range(0, 2000)) - 1000;
      apply();
      tick();
    end
    start = 1'b0;
    repeat (12) tick();
    chk("held_start_count", n_valid - v0, 4);

    // Data changes after accept must not affect the result.
    for (int k = 0; k < 8; k++) for (int n = 0; n < 8; n++) C[k][n] = int'($urandom_range(0, 131072)) - 65536;
    for (int k = 0; k < 8; k++) X[k] = int'($urandom);
    apply();
    e = model();
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 30) begin
      for (int k = 0; k < 8; k++) X[k] = int'($urandom);
      apply();
      tick();
      lat++;
    end
    chk("data_change_latency", lat, 9);
    chk("data_change_result", idct_out, e);
    tick();

    // Reset during the fourth CALC cycle aborts the transform.
    set_identity();
    for (int k = 0; k < 8; k++) X[k] = 100 * (k + 1);
    apply();
    v0 = n_valid;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", valid, 1'b0);
    chk("abort_out", idct_out, '0);
    chk("abort_ready", ready, 1'b1);
    repeat (12) tick();
    chk("abort_no_pulse", n_valid - v0, 0);
    for (int n = 0; n < 8; n++) e[n*DW +: DW] = (n % 2 == 1) ? -(100 * (n + 1)) : 100 * (n + 1);
    run_one("after_abort", e);

    // Full-scale row 0: (2^31-1)^2 >>> 16 wraps to 0xFFFF0000.
    for (int k = 0; k < 8; k++) for (int n = 0; n < 8; n++) C[k][n] = (k == 0) ? 32'h7FFF_FFFF : 0;
    for (int k = 0; k < 8; k++) X[k] = (k == 0) ? 32'h7FFF_FFFF : 0;
    for (int n = 0; n < 8; n++) e[n*DW +: DW] = 32'hFFFF_0000;
    run_one("full_scale", e);

    // Random vectors checked against the model.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) for (int n = 0; n < 8; n++) C[k][n] = int'($urandom);
      for (int k = 0; k < 8; k++) X[k] = int'($urandom);
      run_one("random", model());
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idct_1d_8x1.md
IDCT_1D_8X1 -- requirements
Module: idct_1d_8x1

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, the signed two's-complement width of every data and coefficient element.
REQ-002 SHALL provide parameter FRAC_BITS, default 16, the number of fractional bits in each coefficient; 1.0 = 2^FRAC_BITS.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  DATA_WIDTH*8  DCT coefficients X[0..7]; X[k] at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 coeff_vector  input  DATA_WIDTH*64  basis matrix C; row k at [(7-k)*DATA_WIDTH*8 +: DATA_WIDTH*8]; element C[k][n] within that row at [n*DATA_WIDTH +: DATA_WIDTH]; held stable while busy.
REQ-007 start  input  1  request to begin one 8-point inverse transform.
REQ-008 ready  output  1  high only in IDLE; start is accepted only when ready=1.
REQ-009 idct_out  output  DATA_WIDTH*8  spatial samples x[0..7]; x[n] at [n*DATA_WIDTH +: DATA_WIDTH].
REQ-010 valid  output  1  one-cycle pulse marking a newly updated idct_out.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE plus a 3-bit output index idx.
REQ-012 IDLE: on start=1 at an edge, SHALL latch data_in into an internal input register, set idx=0, go to CALC; start=0 stays IDLE.
REQ-013 Latch SHALL apply the sign fix of the forward block: odd-indexed inputs X[1],X[3],X[5],X[7] stored two's-complement negated; even inputs stored unchanged.
REQ-014 CALC: each cycle SHALL compute x[idx] = (sum over k=0..7 of C[k][idx]*X'[k]) >>> FRAC_BITS using one shared 8-term multiply-add datapath, write it to shadow slot idx, and increment idx.
REQ-015 Products and sum SHALL be carried at 2*DATA_WIDTH+3 bits signed; the shift SHALL be arithmetic; the result SHALL be truncated (wrap, no saturation) to DATA_WIDTH.
REQ-016 CALC with idx=7 SHALL write slot 7 and go to DONE; CALC lasts exactly 8 cycles.
REQ-017 DONE: SHALL copy all 8 shadow slots to idct_out in one edge, assert valid for that one cycle, and return to IDLE.
REQ-018 Latency: start accepted at edge T -> valid=1 and new idct_out visible after edge T+9; ready returns high after edge T+9; next start accepted at edge T+10 earliest.
REQ-019 start while in CALC or DONE SHALL be ignored (no queueing, no restart).
REQ-020 idct_out SHALL change only on the DONE edge and hold its value otherwise, including during a following transform.
REQ-021 data_in changes after the accept edge SHALL not affect the current result.
REQ-022 Datapath SHALL be registered only at the shadow slots and idct_out; no multicycle multiplier pipeline.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, idx=0, valid=0, ready=1 (after the edge), idct_out=0, shadow slots=0, input register=0.
REQ-024 reset asserted during CALC or DONE SHALL abort the transform with no valid pulse and idct_out=0.
REQ-025 reset has priority over start on the same edge.

Verification
REQ-026 Identity C (C[k][k]=65536, else 0), X=[1,2,3,4,5,6,7,8], pulse start -> valid exactly 9 cycles after accept edge, idct_out=[1,-2,3,-4,5,-6,7,-8].
REQ-027 C all 32768 (0.5), X=[10,0,10,0,10,0,10,0] -> every x[n]=20; X=[0,4,0,4,0,4,0,4] -> every x[n]=-8.
REQ-028 Start held high continuously, identity C -> one result per 10 cycles, ready low in CALC/DONE, starts during busy ignored.
REQ-029 Change data_in every cycle after accept -> result equals value for the data latched at accept; idct_out unchanged until valid.
REQ-030 Assert reset at 4th CALC cycle -> no valid pulse, idct_out=0, ready=1 next cycle; fresh start completes normally.
REQ-031 C[0][n]=0x7FFFFFFF for all n, other rows 0, X[0]=0x7FFFFFFF -> idct_out matches truncated arithmetic of REQ-015, bit-exact with reference model.
